// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped BTB with 2-bit saturating counters.
// Lookup is combinational; one entry is written per cycle from resolution.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  output logic [1:0]  prediction,
  output logic        isnew,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        freeze
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];

  logic [IDX_W-1:0] lidx;
  logic [TAG_W-1:0] ltag;
  logic             lhit;

  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic             we;
  logic             tgt_we;
  logic [1:0]       cnt_d;
  logic             unused;

  assign unused = ^update_pc[1:0];

  assign lidx = lookup_pc[IDX_W+1:2];
  assign ltag = lookup_pc[31:IDX_W+2];
  assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);

  assign isnew      = !lhit;
  assign prediction = lhit ? cnt_q[lidx] : 2'b01;
  assign pred_taken = lhit && cnt_q[lidx][1];
  assign pred_npc   = pred_taken ? tgt_q[lidx]
                                 : lookup_pc + 32'd4;

  assign uidx = update_pc[IDX_W+1:2];
  assign utag = update_pc[31:IDX_W+2];
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);
  assign we   = update_en && !freeze && !RST;

  // Allocation always takes the target; a hit only on taken.
  assign tgt_we = !uhit || update_taken;

  always_comb begin
    cnt_d = update_taken ? 2'b10 : 2'b01;
    if (uhit) begin
      cnt_d = cnt_q[uidx];
      if (update_taken) begin
        if (cnt_q[uidx] != 2'b11)
          cnt_d = cnt_q[uidx] + 2'b01;
      end else begin
        if (cnt_q[uidx] != 2'b00)
          cnt_d = cnt_q[uidx] - 2'b01;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[uidx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      tag_q[uidx] <= utag;
      cnt_q[uidx] <= cnt_d;
      if (tgt_we)
        tgt_q[uidx] <= update_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random/directed bench for branch_predictor.
// Expectations come from an arithmetic table model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = $clog2(ENTRIES);

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic [1:0]  prediction;
  logic        isnew;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        freeze;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .CLK(CLK),
    .RST(RST),
    .lookup_pc(lookup_pc),
    .pred_taken(pred_taken),
    .pred_npc(pred_npc),
    .prediction(prediction),
    .isnew(isnew),
    .update_en(update_en),
    .update_pc(update_pc),
    .update_taken(update_taken),
    .update_target(update_target),
    .freeze(freeze)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          v;
    longint      tag;
    logic [31:0] tgt;
    int          cnt;
  } ent_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    bit          isnew;
    int          pred;
    bit          taken;
    logic [31:0] npc;
  } exp_t;

  ent_t m [ENTRIES];
  exp_t q [$];

  int checks = 0;
  int passed = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((longint'(pc) / 4) % ENTRIES);
  endfunction

  function automatic longint tag_of(input logic [31:0] pc);
    return longint'(pc) / (4 * ENTRIES);
  endfunction

  function automatic void check(input string name,
                                input logic [31:0] pc,
                                input longint act,
                                input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s pc=%08h actual=%0h required=%0h",
                  name, pc, act, exp);
  endfunction

  task automatic step(input string name,
                      input bit rst,
                      input bit uen,
                      input logic [31:0] upc,
                      input bit ut,
                      input logic [31:0] utgt,
                      input bit frz,
                      input logic [31:0] lpc);
    exp_t e;
    int   i;
    bit   hit;
    @(posedge CLK);
    #1;
    RST           = rst;
    update_en     = uen;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    freeze        = frz;
    lookup_pc     = lpc;
    // Lookup sees the table as it stands before this cycle's write.
    i = idx_of(lpc);
    hit = m[i].v && (m[i].tag == tag_of(lpc));
    e.name  = name;
    e.pc    = lpc;
    e.isnew = !hit;
    e.pred  = hit ? m[i].cnt : 1;
    e.taken = hit && (m[i].cnt >= 2);
    e.npc   = e.taken ? m[i].tgt : lpc + 32'd4;
    q.push_back(e);
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) m[k].v = 0;
    end else if (uen && !frz) begin
      i = idx_of(upc);
      if (!m[i].v || m[i].tag != tag_of(upc)) begin
        m[i].v   = 1;
        m[i].tag = tag_of(upc);
        m[i].tgt = utgt;
        m[i].cnt = ut ? 2 : 1;
      end else if (ut) begin
        m[i].cnt = (m[i].cnt < 3) ? m[i].cnt + 1 : 3;
        m[i].tgt = utgt;
      end else begin
        m[i].cnt = (m[i].cnt > 0) ? m[i].cnt - 1 : 0;
      end
    end
  endtask

  task automatic look(input string name, input logic [31:0] lpc);
    step(name, 0, 0, 32'h0, 0, 32'h0, 0, lpc);
  endtask

  task automatic upd(input string name,
                     input logic [31:0] upc,
                     input bit ut,
                     input logic [31:0] utgt,
                     input logic [31:0] lpc);
    step(name, 0, 1, upc, ut, utgt, 0, lpc);
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".isnew"}, e.pc, longint'(isnew), longint'(e.isnew));
      check({e.name, ".pred"}, e.pc, longint'(prediction), longint'(e.pred));
      check({e.name, ".taken"}, e.pc, longint'(pred_taken), longint'(e.taken));
      check({e.name, ".npc"}, e.pc, longint'(pred_npc), longint'(e.npc));
    end
  end

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h0000_0040;
    pool[1] = 32'h0000_0440;
    pool[2] = 32'h0000_0080;
    pool[3] = 32'h0000_0043;
    pool[4] = 32'hFFFF_FFFC;
    pool[5] = 32'h0000_1084;
    pool[6] = 32'h0000_07C0;
    pool[7] = 32'h0000_0084;

    RST = 1'b1;
    update_en = 0;
    update_pc = '0;
    update_taken = 0;
    update_target = '0;
    freeze = 0;
    lookup_pc = '0;
    for (int k = 0; k < ENTRIES; k++) m[k].v = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    look("reset", 32'h40);
    upd("alloc_old", 32'h40, 1, 32'h100, 32'h40);
    look("alloc_hit", 32'h40);
    for (int k = 0; k < 4; k++)
      upd("taken_sat", 32'h40, 1, 32'h100, 32'h40);
    look("strong_t", 32'h40);
    for (int k = 0; k < 4; k++)
      upd("nt_sat", 32'h40, 0, 32'h0, 32'h40);
    look("strong_nt", 32'h40);
    upd("alias", 32'h440, 0, 32'h200, 32'h440);
    look("alias_evict", 32'h40);
    look("alias_new", 32'h440);
    step("freeze", 0, 1, 32'h80, 1, 32'h300, 1, 32'h80);
    look("freeze_miss", 32'h80);
    upd("same_cycle", 32'h80, 1, 32'h300, 32'h80);
    look("same_next", 32'h80);
    look("wrap", 32'hFFFF_FFFC);
    step("rst_upd", 1, 1, 32'h84, 1, 32'h400, 0, 32'h80);
    look("post_rst_a", 32'h84);
    look("post_rst_b", 32'h80);
    look("post_rst_c", 32'h440);

    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0,
           pool[$urandom_range(0, 7)],
           $urandom_range(0, 1) == 1,
           {$urandom_range(0, 255), 2'b00},
           $urandom_range(0, 7) == 0,
           pool[$urandom_range(0, 7)]);
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge CLK);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Produces the `prediction` and `isnew` values the hazard unit consumes, plus the predicted next PC for the PC mux.
- Lookup is combinational on the fetch PC.
- Table state is written once per cycle from the branch-resolution stage (EX/MEM) when a conditional branch (beq/bne) retires its outcome.

Parameters:
- ENTRIES, 16, number of direct-mapped BTB entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width; tag = pc[31:IDX_W+2].

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- lookup_pc  input  32  PC of instruction currently in fetch.
- pred_taken  output  1  1 = entry hit and counter[1]==1.
- pred_npc  output  32  pred_taken ? stored target : lookup_pc+4.
- prediction  output  2  counter of hit entry; 2'b01 on miss.
- isnew  output  1  1 = lookup miss (entry invalid or tag mismatch).
- update_en  input  1  resolution stage reports a conditional branch outcome this cycle.
- update_pc  input  32  PC of the resolved branch.
- update_taken  input  1  actual branch outcome.
- update_target  input  32  actual branch target address.
- freeze  input  1  pipeline stall; when 1, no table write occurs even if update_en=1.

Behaviour:
- Storage per entry: valid (1), tag (TAG_W), target (32), cnt (2). Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (RST=1 at a clock edge):
  - All valid bits clear; tag/target/cnt are don't-care.
  - Outputs after reset, for any lookup_pc: isnew=1, prediction=01, pred_taken=0, pred_npc=lookup_pc+4.
  - Reset overrides a simultaneous update.
- Lookup: purely combinational, zero latency. hit = valid[idx] && tag[idx]==lookup_pc tag field.
- Write condition: update_en && !freeze && !RST. At most one entry written per cycle.
- Update on hit (update_pc index and tag match):
  - Taken: cnt = min(cnt+1, 3). Not taken: cnt = max(cnt-1, 0). Saturation is required, never wrap.
  - Target field is overwritten with update_target only when update_taken=1.
- Update on miss (invalid entry or tag conflict): allocate and overwrite the entry.
  - valid=1, tag=update_pc tag field, target=update_target.
  - cnt=10 if taken, 01 if not taken.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-old). The new value is visible the next cycle.
- Aliasing: two PCs with equal index and different tags evict each other. No associativity and no replacement policy.
- Address bits [1:0] of both PCs are ignored.
- pred_npc adder is 32-bit; lookup_pc=0xFFFFFFFC yields 0x00000000 (wraps).
- No internal FSM beyond the per-entry counter automata. No outputs are registered.

Test Plan:
- Reset, then lookup_pc=0x00000040 -> isnew=1, prediction=01, pred_taken=0, pred_npc=0x00000044.
- One update (pc=0x40, taken=1, target=0x100), then lookup 0x40 next cycle -> isnew=0, prediction=10, pred_taken=1, pred_npc=0x100.
- Four consecutive taken updates on 0x40 -> prediction=11, then stays 11. Three not-taken updates -> 10, 01, 00; a further not-taken stays 00 with pred_npc=0x44.
- With 0x40 allocated, update 0x440 (same index when ENTRIES=16, different tag) with taken=0 -> lookup 0x40 gives isnew=1; lookup 0x440 gives prediction=01.
- update_en=1 with freeze=1 for pc=0x80 -> lookup 0x80 next cycle still isnew=1. Same-cycle lookup and update of 0x80 with freeze=0 -> old value (miss) that cycle, hit the following cycle.
- Mid-run RST=1 asserted together with update_en=1 -> every entry reads miss afterward, including the updated PC.
